// File: rtl/bch_pkg.sv
// Shared constants for the 8-bit parallel BCH(t=8, GF(2^13)) encoder.
// The generator polynomial is derived at elaboration from the field's primitive polynomial.
package bch_pkg;

    localparam int unsigned GF_M          = 13;
    localparam int unsigned T             = 8;
    localparam int unsigned PAR_BITS      = GF_M * T;
    localparam int unsigned K_BYTES_DEF   = 512;
    localparam int unsigned PAR_BYTES_DEF = PAR_BITS / 8;

    // x^13 + x^4 + x^3 + x + 1, leading term implied
    localparam logic [GF_M-1:0] PRIM_POLY = 13'h001B;

    localparam logic [0:0] StData   = 1'b0;
    localparam logic [0:0] StParity = 1'b1;

    function automatic logic [GF_M-1:0] gf_mul(input logic [GF_M-1:0] a,
                                              input logic [GF_M-1:0] b);
        logic [GF_M-1:0] r;
        logic [GF_M-1:0] x;
        r = '0;
        x = a;
        for (int i = 0; i < int'(GF_M); i++) begin
            if (b[i]) r = r ^ x;
            x = x[GF_M-1] ? ({x[GF_M-2:0], 1'b0} ^ PRIM_POLY) : {x[GF_M-2:0], 1'b0};
        end
        return r;
    endfunction

    // g(x) = product of the minimal polynomials of alpha^1, alpha^3, ..., alpha^(2T-1)
    function automatic logic [PAR_BITS-1:0] calc_gen_poly();
        logic [PAR_BITS:0] g;
        logic [PAR_BITS:0] acc;
        logic [GF_M-1:0]   beta;
        logic [GF_M-1:0]   conj;
        logic [GF_M-1:0]   mp [GF_M+1];
        g    = {{PAR_BITS{1'b0}}, 1'b1};
        beta = 13'd2;
        for (int i = 1; i < int'(2 * T); i += 2) begin
            for (int k = 0; k <= int'(GF_M); k++) mp[k] = '0;
            mp[0] = 13'd1;
            conj  = beta;
            for (int j = 0; j < int'(GF_M); j++) begin
                for (int k = GF_M; k > 0; k--) mp[k] = mp[k-1] ^ gf_mul(mp[k], conj);
                mp[0] = gf_mul(mp[0], conj);
                conj  = gf_mul(conj, conj);
            end
            acc = '0;
            for (int k = 0; k <= int'(GF_M); k++) begin
                if (mp[k][0]) acc = acc ^ (g << k);
            end
            g    = acc;
            beta = gf_mul(beta, 13'd4);
        end
        return g[PAR_BITS-1:0];
    endfunction

    localparam logic [PAR_BITS-1:0] GEN_POLY = calc_gen_poly();

endpackage

// File: rtl/bch_encoder_8_lfsr.sv
// One byte-wide step of the systematic remainder register, MSB of the byte first.
module bch_lfsr_step8
    import bch_pkg::*;
(
    input  logic [PAR_BITS-1:0] rem_i,
    input  logic [7:0]          data_i,
    output logic [PAR_BITS-1:0] rem_o
);

    logic [PAR_BITS-1:0] r;
    logic                fb;

    always_comb begin
        r  = rem_i;
        fb = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            fb = r[PAR_BITS-1] ^ data_i[i];
            r  = {r[PAR_BITS-2:0], 1'b0} ^ ({PAR_BITS{fb}} & GEN_POLY);
        end
        rem_o = r;
    end

endmodule

// File: rtl/bch_encoder_8.sv
// Streaming systematic BCH encoder: forwards K_BYTES message bytes, then PAR_BYTES parity bytes.
// Single output register stage with valid/ready on both sides.
module bch_encoder_8
    import bch_pkg::*;
#(
    parameter int unsigned K_BYTES   = K_BYTES_DEF,
    parameter int unsigned PAR_BYTES = PAR_BYTES_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       out_last
);

    localparam int unsigned CntMax = (K_BYTES > PAR_BYTES) ? K_BYTES : PAR_BYTES;
    localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;
    localparam logic [CntW-1:0] LastMsg = CntW'(K_BYTES - 1);
    localparam logic [CntW-1:0] LastPar = CntW'(PAR_BYTES - 1);

    logic [0:0]          state_q,     state_d;
    logic [CntW-1:0]     cnt_q,       cnt_d;
    logic [PAR_BITS-1:0] rem_q,       rem_d;
    logic                out_valid_q, out_valid_d;
    logic                out_last_q,  out_last_d;
    logic [7:0]          out_data_q,  out_data_d;

    logic [PAR_BITS-1:0] rem_step;
    logic                out_free;
    logic                accept;

    bch_lfsr_step8 u_lfsr_step (
        .rem_i  (rem_q),
        .data_i (in_data),
        .rem_o  (rem_step)
    );

    assign out_free  = !out_valid_q || out_ready;
    assign in_ready  = !rst && (state_q == StData) && out_free;
    assign accept    = in_valid && in_ready;

    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign out_data  = out_data_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_data_d  = out_data_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end

        case (state_q)
            StParity: begin
                if (out_free) begin
                    out_data_d  = rem_q[PAR_BITS-1 -: 8];
                    rem_d       = {rem_q[PAR_BITS-9:0], 8'h00};
                    out_valid_d = 1'b1;
                    out_last_d  = (cnt_q == LastPar);
                    // Leaving on load of the last parity byte keeps the next message gap-free
                    if (cnt_q == LastPar) begin
                        state_d = StData;
                        cnt_d   = '0;
                        rem_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
            end
            default: begin
                if (accept) begin
                    out_data_d  = in_data;
                    out_valid_d = 1'b1;
                    out_last_d  = 1'b0;
                    rem_d       = rem_step;
                    if (cnt_q == LastMsg) begin
                        state_d = StParity;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StData;
            cnt_q       <= '0;
            rem_q       <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_data_q  <= out_data_d;
        end
    end

endmodule

// File: tb/tb_bch_encoder_8.sv
// Scoreboard bench for bch_encoder_8: reference codewords by polynomial long division,
// plus a syndrome decoder over GF(2^13) applied to every emitted codeword.
module tb_bch_encoder_8;
    import bch_pkg::*;

    localparam int K        = 512;
    localparam int P        = 13;
    localparam int N_BITS   = K * 8 + 104;
    localparam int CW_BYTES = K + P;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_last;

    bch_encoder_8 #(.K_BYTES(K), .PAR_BYTES(P)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } exp_t;

    exp_t       exp_q [$];
    logic [7:0] rx_q [$];
    logic [7:0] msg [K];
    bit         cw_bits [N_BITS];
    int         n_checks = 0;
    int         n_pass   = 0;
    bit         rand_ready = 1'b0;
    logic [104:0] gfull;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // GF(2^13) multiply: carry-less product, then reduce by x^13+x^4+x^3+x+1
    function automatic logic [12:0] fmul(input logic [12:0] a, input logic [12:0] b);
        logic [24:0] p;
        p = '0;
        for (int i = 0; i < 13; i++) if (b[i]) p = p ^ (25'(a) << i);
        for (int d = 24; d >= 13; d--) if (p[d]) p = p ^ (25'h201B << (d - 13));
        return p[12:0];
    endfunction

    function automatic logic [12:0] alpha_pow(input int e);
        logic [12:0] r;
        r = 13'd1;
        for (int i = 0; i < e; i++) r = fmul(r, 13'd2);
        return r;
    endfunction

    // m(x)*x^104 mod g(x) by long division over the whole codeword bit array
    function automatic logic [103:0] ref_parity();
        logic [103:0] p;
        for (int d = 0; d < N_BITS; d++) cw_bits[d] = 1'b0;
        for (int b = 0; b < K; b++)
            for (int j = 0; j < 8; j++) cw_bits[N_BITS - 1 - (b * 8 + 7 - j)] = msg[b][j];
        for (int d = N_BITS - 1; d >= 104; d--)
            if (cw_bits[d])
                for (int k = 0; k <= 104; k++) cw_bits[d - 104 + k] = cw_bits[d - 104 + k] ^ gfull[k];
        for (int k = 0; k < 104; k++) p[k] = cw_bits[k];
        return p;
    endfunction

    // Decoder side: all syndromes S1, S3, ..., S15 of the received word must vanish
    function automatic bit syndromes_zero();
        logic [12:0] beta;
        logic [12:0] acc;
        for (int i = 1; i < 16; i += 2) begin
            beta = alpha_pow(i);
            acc  = '0;
            foreach (rx_q[n])
                for (int j = 7; j >= 0; j--) acc = fmul(acc, beta) ^ {12'b0, rx_q[n][j]};
            if (acc != 13'd0) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic push_codeword(input logic [103:0] parity);
        for (int b = 0; b < K; b++) exp_q.push_back({msg[b], 1'b0});
        for (int i = 0; i < P; i++) exp_q.push_back({parity[103 - 8 * i -: 8], i == P - 1});
    endtask

    task automatic send_byte(input logic [7:0] d, input bit stall, output int waits);
        bit acc;
        waits = 0;
        if (stall) begin
            while ($urandom_range(0, 1) == 1) begin
                in_valid = 1'b0;
                @(posedge clk);
                #1;
            end
        end
        in_valid = 1'b1;
        in_data  = d;
        forever begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) break;
            waits++;
            if (waits > 2000) begin
                $display("FAIL in_ready_timeout: waited %0d cycles, expected acceptance", waits);
                $fatal(1, "input stuck");
            end
        end
    endtask

    task automatic send_msg(input bit stall, input int n_bytes, output int first_wait);
        int w;
        first_wait = 0;
        for (int b = 0; b < n_bytes; b++) begin
            send_byte(msg[b], stall, w);
            if (b == 0) first_wait = w;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 5000 && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        check("drain_queue_empty", exp_q.size(), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: pops the scoreboard on every output transfer, checks hold-while-stalled
    initial begin
        bit         prev_stall;
        logic [7:0] prev_data;
        logic       prev_last;
        int         xfer_cnt;
        exp_t       e;
        prev_stall = 1'b0;
        xfer_cnt   = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
                xfer_cnt   = 0;
                rx_q.delete();
            end else begin
                if (prev_stall) begin
                    check("stall_hold_valid", out_valid, 1'b1);
                    check("stall_hold_data", out_data, prev_data);
                    check("stall_hold_last", out_last, prev_last);
                end
                if (out_valid && out_ready) begin
                    check("expected_available", exp_q.size() > 0, 1'b1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check("out_data", out_data, e.data);
                        check("out_last", out_last, e.last);
                    end
                    xfer_cnt++;
                    rx_q.push_back(out_data);
                    if (out_last) begin
                        check("codeword_length", xfer_cnt, CW_BYTES);
                        check("syndromes_zero", syndromes_zero(), 1'b1);
                        xfer_cnt = 0;
                        rx_q.delete();
                    end
                end
                prev_stall = out_valid && !out_ready;
                prev_data  = out_data;
                prev_last  = out_last;
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          w;
        logic [12:0] acc;
        gfull    = {1'b1, GEN_POLY};
        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'hA5;
        repeat (3) @(posedge clk);
        #1;
        check("reset_in_ready", in_ready, 1'b0);
        check("reset_out_valid", out_valid, 1'b0);
        check("reset_out_last", out_last, 1'b0);
        check("reset_out_data", out_data, 8'h00);
        rst      = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("idle_out_valid", out_valid, 1'b0);

        // alpha^1..alpha^16 must all be roots of g(x)
        for (int i = 1; i <= 16; i++) begin
            acc = '0;
            for (int d = 104; d >= 0; d--) acc = fmul(acc, alpha_pow(i)) ^ {12'b0, gfull[d]};
            check("gen_poly_root", acc, 13'd0);
        end

        // All-zero message: zero parity
        for (int b = 0; b < K; b++) msg[b] = 8'h00;
        push_codeword(104'd0);
        send_msg(1'b0, K, w);
        in_valid = 1'b0;
        drain();

        // m(x) = 1: parity is g(x) without its leading term
        msg[K-1] = 8'h01;
        push_codeword(GEN_POLY);
        send_msg(1'b0, K, w);
        in_valid = 1'b0;
        drain();

        // Three random codewords back-to-back at full throughput
        for (int m = 0; m < 3; m++) begin
            for (int b = 0; b < K; b++) msg[b] = 8'($urandom);
            push_codeword(ref_parity());
            send_msg(1'b0, K, w);
            if (m > 0) check("in_ready_low_gap", w, 13);
        end
        in_valid = 1'b0;
        drain();

        // Same last message again, then a fresh one, with random stalls on both sides
        rand_ready = 1'b1;
        push_codeword(ref_parity());
        send_msg(1'b1, K, w);
        for (int b = 0; b < K; b++) msg[b] = 8'($urandom);
        push_codeword(ref_parity());
        send_msg(1'b1, K, w);
        in_valid   = 1'b0;
        rand_ready = 1'b0;
        drain();

        // Reset after byte 200, then the full message must encode as from a fresh reset
        for (int b = 0; b < K; b++) msg[b] = 8'($urandom);
        push_codeword(ref_parity());
        send_msg(1'b0, 201, w);
        rst      = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("mid_reset_out_valid", out_valid, 1'b0);
        check("mid_reset_in_ready", in_ready, 1'b0);
        exp_q.delete();
        rst = 1'b0;
        @(posedge clk);
        #1;
        push_codeword(ref_parity());
        send_msg(1'b0, K, w);
        in_valid = 1'b0;
        drain();

        check("final_out_valid", out_valid, 1'b0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
